// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants and pixel colour type used by the
// scan controller and every sprite renderer.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = 525;

    typedef logic [11:0] rgb_t;

    localparam rgb_t FG_DEFAULT = 12'hFFF;
    localparam rgb_t BG_DEFAULT = 12'h000;
endpackage

// File: rtl/vga_align_pipe.sv
// Fixed-depth delay line with a per-bit reset value; lines raster control up
// with the renderer's px latency.
module vga_align_pipe #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (RESET) begin
            stage <= {DEPTH{RST_VAL}};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/vga_scan_ctrl.sv
// 640x480@60 scan master: raster counters, renderer addressing, sync/blank aligned
// to the px latency. Define VGA_BORDER_EN to force a one-pixel FG_RGB frame.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int   PX_LAT = 1,
    parameter rgb_t FG_RGB = FG_DEFAULT,
    parameter rgb_t BG_RGB = BG_DEFAULT
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        px,
    output logic [8:0]  row_addr,
    output logic [9:0]  col_addr,
    output logic        fresh,
    output logic        hs,
    output logic        vs,
    output logic [11:0] rgb,
    output logic [15:0] frame_cnt
);
    logic [9:0]  h_cnt, v_cnt, h_next, v_next;
    logic        h_end, v_end;
    logic [15:0] frame_q;
    logic        video_on, hs_raw, vs_raw;
    logic [2:0]  ctl_d;
    logic        video_on_d, hs_d, vs_d, pix_on;

    assign h_end = (h_cnt == 10'(H_TOTAL - 1));
    assign v_end = (v_cnt == 10'(V_TOTAL - 1));

    always_comb begin
        h_next = h_end ? 10'd0 : h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_end) v_next = v_end ? 10'd0 : v_cnt + 10'd1;
    end

    // fresh is taken from the next count so it toggles on the same edge as v_cnt
    always_ff @(posedge clk) begin
        if (RESET) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            fresh   <= 1'b1;
            frame_q <= '0;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            fresh <= (v_next < 10'(V_ACTIVE));
            if (h_end && v_end) frame_q <= frame_q + 16'd1;
        end
    end

    assign row_addr  = v_cnt[8:0];
    assign col_addr  = h_cnt;
    assign frame_cnt = frame_q;

    assign video_on = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign hs_raw   = !((h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw   = !((v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)));

    vga_align_pipe #(.DEPTH(PX_LAT), .WIDTH(3), .RST_VAL(3'b011)) u_ctl_pipe (
        .clk   (clk),
        .RESET (RESET),
        .d     ({video_on, hs_raw, vs_raw}),
        .q     (ctl_d)
    );
    assign {video_on_d, hs_d, vs_d} = ctl_d;

`ifdef VGA_BORDER_EN
    logic [18:0] pos_d;
    logic [8:0]  row_d;
    logic [9:0]  col_d;

    vga_align_pipe #(.DEPTH(PX_LAT), .WIDTH(19), .RST_VAL(19'd0)) u_pos_pipe (
        .clk   (clk),
        .RESET (RESET),
        .d     ({row_addr, col_addr}),
        .q     (pos_d)
    );
    assign {row_d, col_d} = pos_d;
    assign pix_on = px || (row_d == 9'd0) || (row_d == 9'(V_ACTIVE - 1))
                       || (col_d == 10'd0) || (col_d == 10'(H_ACTIVE - 1));
`else
    assign pix_on = px;
`endif

    // Syncs get the same output register as rgb so all pins share PX_LAT+1 latency
    always_ff @(posedge clk) begin
        if (RESET) begin
            hs  <= 1'b1;
            vs  <= 1'b1;
            rgb <= '0;
        end else begin
            hs  <= hs_d;
            vs  <= vs_d;
            rgb <= video_on_d ? (pix_on ? FG_RGB : BG_RGB) : 12'h000;
        end
    end
endmodule
